// File: rtl/shift595_pkg.sv
// rtl/shift595_pkg.sv - shared state type and PWM width for the 74HC595 chain driver
package shift595_pkg;

    localparam int PWM_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/shift595_chain_driver_pwm.sv
// rtl/shift595_chain_driver_pwm.sv - free-running PWM dimming of the 595 output enable
// Module shift595_pwm; only instantiated when SHIFT595_PWM_EN is defined.
module shift595_pwm
    import shift595_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] brightness,
    output logic             oe_n
);

    logic [PWM_W-1:0] pwm_cnt;

    // Outputs stay enabled for `brightness` counts out of every 2**PWM_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            oe_n    <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            oe_n    <= (pwm_cnt >= brightness);
        end
    end

endmodule

// File: rtl/shift595_chain_driver.sv
// rtl/shift595_chain_driver.sv - serialises a parallel LED pattern into a chain of 74HC595 devices
// Optional macro SHIFT595_PWM_EN adds a brightness input driving led595_oe_n.
module shift595_chain_driver
    import shift595_pkg::*;
#(
    parameter int CHAIN_LEN = 1,
    parameter int CLK_DIV   = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef SHIFT595_PWM_EN
    input  logic [PWM_W-1:0]       brightness,
`endif
    input  logic [8*CHAIN_LEN-1:0] led_data,
    input  logic                   update_req,
    output logic                   busy,
    output logic                   done,
    output logic                   led595_dout,
    output logic                   led595_clk,
    output logic                   led595_latch,
    output logic                   led595_oe_n
);

    localparam int N     = 8 * CHAIN_LEN;
    localparam int BIT_W = $clog2(N + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

    state_t           state;
    logic [N-1:0]     shreg;
    logic [N-1:0]     shadow;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             pending;
    logic             want;

    assign want = pending || (led_data != shadow) || update_req;

    // The shift register fills with zeros as it empties, so dout is 0 outside SHIFT.
    assign led595_dout = LSB_FIRST ? shreg[0] : shreg[N-1];

    function automatic logic [N-1:0] advance(input logic [N-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            shadow       <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            pending      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            led595_clk   <= 1'b0;
            led595_latch <= 1'b0;
        end else begin
            done    <= 1'b0;
            pending <= want;
            case (state)
                IDLE: begin
                    if (want) begin
                        state      <= SHIFT;
                        shreg      <= led_data;
                        shadow     <= led_data;
                        pending    <= 1'b0;
                        busy       <= 1'b1;
                        bit_cnt    <= '0;
                        div_cnt    <= '0;
                        led595_clk <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (div_cnt == LAST_DIV) begin
                        div_cnt <= '0;
                        if (!led595_clk) begin
                            led595_clk <= 1'b1;
                        end else begin
                            led595_clk <= 1'b0;
                            shreg      <= advance(shreg);
                            if (bit_cnt == LAST_BIT) begin
                                state        <= LATCH;
                                led595_latch <= 1'b1;
                                bit_cnt      <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                LATCH: begin
                    if (div_cnt == LAST_DIV) begin
                        state        <= IDLE;
                        div_cnt      <= '0;
                        led595_latch <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHIFT595_PWM_EN
    shift595_pwm u_pwm (
        .clk        (clk),
        .rst        (rst),
        .brightness (brightness),
        .oe_n       (led595_oe_n)
    );
`else
    assign led595_oe_n = 1'b0;
`endif

endmodule

// File: tb/tb_shift595_chain_driver.sv
// tb/tb_shift595_chain_driver.sv - randomized scoreboard bench for shift595_chain_driver (SHIFT595_PWM_EN optional)
`timescale 1ns/1ps
module tb_shift595_chain_driver;

    localparam int NN [2] = '{8, 16};
    localparam int DD [2] = '{4, 2};
    localparam bit LF [2] = '{1'b0, 1'b1};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, upd0, upd1;
    logic [7:0]  ld0;
    logic [15:0] ld1;
    logic [7:0]  bright;
    logic [1:0]  busy, done, dout, sclk, latch, oe_n, rst_v;
    assign rst_v = {rst1, rst0};

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];
    int pushed [2] = '{0, 0};

    shift595_chain_driver #(.CHAIN_LEN(1), .CLK_DIV(4), .LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst0),
`ifdef SHIFT595_PWM_EN
        .brightness(bright),
`endif
        .led_data(ld0), .update_req(upd0), .busy(busy[0]), .done(done[0]),
        .led595_dout(dout[0]), .led595_clk(sclk[0]), .led595_latch(latch[0]), .led595_oe_n(oe_n[0])
    );

    shift595_chain_driver #(.CHAIN_LEN(2), .CLK_DIV(2), .LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst1),
`ifdef SHIFT595_PWM_EN
        .brightness(bright),
`endif
        .led_data(ld1), .update_req(upd1), .busy(busy[1]), .done(done[1]),
        .led595_dout(dout[1]), .led595_clk(sclk[1]), .led595_latch(latch[1]), .led595_oe_n(oe_n[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: reassemble each frame as a 595 chain would see it and check timing.
    int busy_cyc [2] = '{0, 0};
    int latch_cyc [2] = '{0, 0};
    int nbits [2] = '{0, 0};
    int run [2] = '{0, 0};
    int frames [2] = '{0, 0};
    int done_cyc [2] = '{-100, -100};
    int gap [2] = '{0, 0};
    int cyc = 0;
    logic [15:0] cap [2] = '{16'h0, 16'h0};
    logic [1:0] prev_sclk = 2'b0, prev_busy = 2'b0, rst_d = 2'b0;

    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (rst_v[g]) begin
                if (rst_d[g])
                    check($sformatf("reset_outs%0d", g), {busy[g], done[g], dout[g], sclk[g], latch[g]}, 5'b0);
                busy_cyc[g] = 0; latch_cyc[g] = 0; nbits[g] = 0; cap[g] = '0; run[g] = 0;
            end else begin
                if (busy[g] && !prev_busy[g]) begin
                    gap[g] = cyc - done_cyc[g];
                    run[g] = 0;
                end
                if (busy[g]) begin
                    busy_cyc[g]++;
                    if (sclk[g] != prev_sclk[g]) begin
                        check($sformatf("half_period%0d", g), run[g], DD[g]);
                        run[g] = 1;
                    end else begin
                        run[g]++;
                    end
                    if (sclk[g] && !prev_sclk[g]) begin
                        nbits[g]++;
                        if (LF[g]) cap[g] = (cap[g] >> 1) | (16'(dout[g]) << (NN[g] - 1));
                        else       cap[g] = {cap[g][14:0], dout[g]};
                    end
                    if (latch[g]) begin
                        latch_cyc[g]++;
                        check($sformatf("latch_quiet%0d", g), {sclk[g], dout[g]}, 2'b0);
                    end
                end else begin
                    check($sformatf("idle_quiet%0d", g), {dout[g], sclk[g], latch[g]}, 3'b0);
                end
                if (done[g]) begin
                    logic        ok;
                    logic [15:0] e;
                    if (g == 0) begin ok = exp_q0.size() > 0; e = ok ? exp_q0.pop_front() : '0; end
                    else        begin ok = exp_q1.size() > 0; e = ok ? exp_q1.pop_front() : '0; end
                    check($sformatf("frame_expected%0d", g), ok, 1'b1);
                    check($sformatf("frame_len%0d", g), busy_cyc[g], 2 * NN[g] * DD[g] + DD[g]);
                    check($sformatf("latch_len%0d", g), latch_cyc[g], DD[g]);
                    check($sformatf("bit_count%0d", g), nbits[g], NN[g]);
                    check($sformatf("frame_data%0d", g), cap[g], e);
                    frames[g]++;
                    done_cyc[g] = cyc;
                    busy_cyc[g] = 0; latch_cyc[g] = 0; nbits[g] = 0; cap[g] = '0;
                end
            end
            prev_sclk[g] = sclk[g];
            prev_busy[g] = busy[g];
            rst_d[g]     = rst_v[g];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int g, input int target);
        int n = 0;
        while (frames[g] < target && n < 5000) begin
            step(1);
            n++;
        end
        check($sformatf("frame_timeout%0d", g), frames[g] >= target, 1'b1);
    endtask

    task automatic wait_busy(input int g);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!busy[g] && n < 200);
        check($sformatf("busy_timeout%0d", g), busy[g], 1'b1);
    endtask

    // At most one frame may wait behind the one in flight, otherwise changes collapse.
    task automatic wait_slot(input int g);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (pushed[g] - frames[g] > 1 && n < 5000);
        check($sformatf("slot_timeout%0d", g), pushed[g] - frames[g] <= 1, 1'b1);
    endtask

    task automatic set_new(input int g);
        if (g == 0) begin
            logic [7:0] v;
            do v = 8'($urandom); while (v == ld0);
            ld0 = v;
            exp_q0.push_back({8'h00, v});
        end else begin
            logic [15:0] v;
            do v = 16'($urandom); while (v == ld1);
            ld1 = v;
            exp_q1.push_back(v);
        end
        pushed[g]++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        rst0 = 1'b1; rst1 = 1'b1; upd0 = 1'b0; upd1 = 1'b0;
        ld0 = '0; ld1 = '0; bright = 8'd0;
        step(3);
        check("reset_state", {busy, done, dout, sclk, latch}, 10'b0);

        // Reset refresh shifts the all-zero pattern, then the new data follows.
        exp_q0.push_back(16'h0000); exp_q1.push_back(16'h0000);
        pushed[0] = 1; pushed[1] = 1;
        rst0 = 1'b0; rst1 = 1'b0;
        wait_busy(0);
        ld0 = 8'hA5;  exp_q0.push_back(16'h00A5); pushed[0]++;
        ld1 = 16'h0001; exp_q1.push_back(16'h0001); pushed[1]++;
        wait_frames(0, pushed[0]);
        wait_frames(1, pushed[1]);

        // Data change 10 cycles into a frame: frame unchanged, next starts right after done.
        step(5);
        set_new(0);
        wait_busy(0);
        step(10);
        set_new(0);
        wait_frames(0, pushed[0]);
        check("back_to_back", gap[0], 1);

        // update_req with unchanged data: exactly one frame, busy the next cycle.
        step(20);
        upd0 = 1'b1;
        step(1);
        upd0 = 1'b0;
        check("busy_after_upd", busy[0], 1'b1);
        exp_q0.push_back({8'h00, ld0}); pushed[0]++;
        wait_frames(0, pushed[0]);
        step(300);
        check("one_frame_upd", frames[0], pushed[0]);

        // update_req coinciding with a data change: still one frame.
        set_new(0);
        upd0 = 1'b1;
        step(1);
        upd0 = 1'b0;
        wait_frames(0, pushed[0]);
        step(300);
        check("one_frame_both", frames[0], pushed[0]);

        for (int i = 0; i < 12; i++) begin
            for (int g = 0; g < 2; g++) begin
                wait_slot(g);
                step($urandom_range(0, 80));
                set_new(g);
            end
        end
        wait_frames(0, pushed[0]);
        wait_frames(1, pushed[1]);

        // Reset in the middle of SHIFT: outputs clear, then a refresh of current data.
        step(5);
        set_new(0);
        wait_busy(0);
        step(20);
        rst0 = 1'b1;
        step(2);
        check("mid_reset_outs", {busy[0], done[0], dout[0], sclk[0], latch[0]}, 5'b0);
`ifdef SHIFT595_PWM_EN
        check("pwm_reset_oe", oe_n[0], 1'b1);
`endif
        step(2);
        exp_q0.delete();
        exp_q0.push_back({8'h00, ld0});
        pushed[0] = frames[0] + 1;
        rst0 = 1'b0;
        wait_frames(0, pushed[0]);

        step(300);
        check("no_extra_frames0", frames[0], pushed[0]);
        check("no_extra_frames1", frames[1], pushed[1]);
        check("idle_busy", busy, 2'b00);

`ifdef SHIFT595_PWM_EN
        bright = 8'd64;
        step(4);
        lows = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (!oe_n[0]) lows++;
        end
        check("pwm_64", lows, 64);
        bright = 8'd0;
        step(4);
        lows = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (!oe_n[0]) lows++;
        end
        check("pwm_0", lows, 0);
`else
        check("oe_n_const", oe_n, 2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
